// File: rtl/snake_event_gen.sv
// snake_event_gen: moves the snake head on a grid at a divided-clock rate,
// keeps the body in a shift buffer, and emits single-cycle food (good),
// wall/self (bad) and accepted-direction pulses for the sound front end.
module snake_event_gen #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int MAX_LEN  = 16,
  parameter int TICK_DIV = 25
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] dir_i,
  input  logic       restart_i,
  input  logic [3:0] food_x,
  input  logic [3:0] food_y,
  input  logic       food_valid,
  output logic       good_coll,
  output logic       bad_coll,
  output logic [3:0] dir_o,
  output logic [3:0] head_x,
  output logic [3:0] head_y,
  output logic [4:0] length,
  output logic       dead
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  localparam logic [MAX_LEN-1:0][3:0] SEG_X_INIT = {{(MAX_LEN-2){4'd0}}, 4'd7, 4'd8};
  localparam logic [MAX_LEN-1:0][3:0] SEG_Y_INIT = {{(MAX_LEN-2){4'd0}}, 4'd8, 4'd8};

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               dir_q, dir_prev_q;
  logic                     rst_btn_q, rst_prev_q;
  logic [3:0]               heading_q, heading_d;
  logic [3:0]               pending_q, pending_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MAX_LEN-1:0][3:0]  seg_x_q, seg_x_d;
  logic [MAX_LEN-1:0][3:0]  seg_y_q, seg_y_d;
  logic [4:0]               len_q, len_d;
  logic                     good_q, good_d;
  logic                     bad_q, bad_d;
  logic [3:0]               dir_o_q, dir_o_d;

  logic [3:0]         rose;
  logic [3:0]         heading_rev;
  logic               accept;
  logic               restart_press;
  logic [4:0]         hx_inc, hy_inc;
  logic [3:0]         nx, ny;
  logic               wall;
  logic               self_hit;
  logic               food_hit;
  logic [MAX_LEN-1:0] body_match;

  assign rose          = dir_q & ~dir_prev_q;
  assign heading_rev   = {heading_q[2], heading_q[3], heading_q[0], heading_q[1]};
  assign accept        = (state_q != DEAD) && $onehot(dir_q) && (rose == dir_q) &&
                         (dir_q != heading_rev) && (dir_q != pending_q);
  assign restart_press = rst_btn_q & ~rst_prev_q;

  assign hx_inc = {1'b0, seg_x_q[0]} + 5'd1;
  assign hy_inc = {1'b0, seg_y_q[0]} + 5'd1;

  // Button conditioning: one register stage plus a history stage for edge detection
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      dir_q      <= '0;
      dir_prev_q <= '0;
      rst_btn_q  <= 1'b0;
      rst_prev_q <= 1'b0;
    end else begin
      dir_q      <= dir_i;
      dir_prev_q <= dir_q;
      rst_btn_q  <= restart_i;
      rst_prev_q <= rst_btn_q;
    end
  end

  // Candidate next head along the pending direction and its wall check
  always_comb begin
    nx   = seg_x_q[0];
    ny   = seg_y_q[0];
    wall = 1'b0;
    case (pending_q)
      DIR_UP: begin
        wall = (seg_y_q[0] == 4'd0);
        ny   = seg_y_q[0] - 4'd1;
      end
      DIR_DOWN: begin
        wall = (hy_inc >= 5'(GRID_H));
        ny   = hy_inc[3:0];
      end
      DIR_LEFT: begin
        wall = (seg_x_q[0] == 4'd0);
        nx   = seg_x_q[0] - 4'd1;
      end
      DIR_RIGHT: begin
        wall = (hx_inc >= 5'(GRID_W));
        nx   = hx_inc[3:0];
      end
      default: ;
    endcase
  end

  // Body cells 1..length-2 only: the tail cell vacates on the same move
  assign body_match[0] = 1'b0;
  for (genvar g = 1; g < MAX_LEN; g++) begin : g_match
    assign body_match[g] = (6'(g + 2) <= {1'b0, len_q}) &&
                           (seg_x_q[g] == nx) && (seg_y_q[g] == ny);
  end

  assign self_hit = |body_match;
  assign food_hit = food_valid && (nx == food_x) && (ny == food_y);

  // Next-state: direction accept, tick divider, move resolution, restart
  always_comb begin
    state_d   = state_q;
    heading_d = heading_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    seg_x_d   = seg_x_q;
    seg_y_d   = seg_y_q;
    len_d     = len_q;
    good_d    = 1'b0;
    bad_d     = 1'b0;
    dir_o_d   = '0;

    if (accept) begin
      pending_d = dir_q;
      dir_o_d   = dir_q;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          // the move consumes the pending direction registered before this edge;
          // a press accepted on this same edge only lands in pending_d
          heading_d = pending_q;
          if (wall || self_hit) begin
            bad_d   = 1'b1;
            state_d = DEAD;
          end else begin
            seg_x_d = {seg_x_q[MAX_LEN-2:0], nx};
            seg_y_d = {seg_y_q[MAX_LEN-2:0], ny};
            if (food_hit) begin
              good_d = 1'b1;
              if (len_q != 5'(MAX_LEN)) len_d = len_q + 5'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DEAD: begin
        if (restart_press) begin
          state_d   = IDLE;
          heading_d = DIR_RIGHT;
          pending_d = DIR_RIGHT;
          cnt_d     = '0;
          seg_x_d   = SEG_X_INIT;
          seg_y_d   = SEG_Y_INIT;
          len_d     = 5'd2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Game state and pulse registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      heading_q <= DIR_RIGHT;
      pending_q <= DIR_RIGHT;
      cnt_q     <= '0;
      seg_x_q   <= SEG_X_INIT;
      seg_y_q   <= SEG_Y_INIT;
      len_q     <= 5'd2;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      dir_o_q   <= '0;
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      seg_x_q   <= seg_x_d;
      seg_y_q   <= seg_y_d;
      len_q     <= len_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      dir_o_q   <= dir_o_d;
    end
  end

  assign good_coll = good_q;
  assign bad_coll  = bad_q;
  assign dir_o     = dir_o_q;
  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign length    = len_q;
  assign dead      = (state_q == DEAD);

endmodule

// File: tb/tb_snake_event_gen.sv
// Testbench for snake_event_gen: vector table, hand-written game scenarios,
// and a randomized run compared every cycle against a queue-based game model.
module tb_snake_event_gen;

  localparam int TD = 4;
  localparam int GW = 16;
  localparam int GH = 16;
  localparam int ML = 6;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic [3:0] dir_i = '0;
  logic       restart_i = 1'b0;
  logic [3:0] food_x = '0;
  logic [3:0] food_y = '0;
  logic       food_valid = 1'b0;
  logic       good_coll, bad_coll, dead;
  logic [3:0] dir_o, head_x, head_y;
  logic [4:0] length;

  snake_event_gen #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .TICK_DIV(TD)) dut (
    .clk(clk), .nRst(nRst), .dir_i(dir_i), .restart_i(restart_i),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .good_coll(good_coll), .bad_coll(bad_coll), .dir_o(dir_o),
    .head_x(head_x), .head_y(head_y), .length(length), .dead(dead)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // direction codes: 0 up, 1 down, 2 left, 3 right; opposite = code ^ 1
  logic [3:0] m_dir_r, m_dir_prev;
  logic       m_rst_r, m_rst_prev;
  int         m_state;          // 0 idle, 1 run, 2 dead
  int         m_head, m_pend, m_since;
  logic [7:0] m_body[$];        // {x, y}, head first
  logic       e_good, e_bad;
  logic [3:0] e_dir;

  function automatic int dx(input int c);
    return (c == 2) ? -1 : (c == 3) ? 1 : 0;
  endfunction

  function automatic int dy(input int c);
    return (c == 0) ? -1 : (c == 1) ? 1 : 0;
  endfunction

  task automatic model_reset_game();
    m_state = 0;
    m_body.delete();
    m_body.push_back({4'd8, 4'd8});
    m_body.push_back({4'd7, 4'd8});
    m_head  = 3;
    m_pend  = 3;
    m_since = 0;
  endtask

  task automatic model_reset_all();
    model_reset_game();
    m_dir_r = '0; m_dir_prev = '0; m_rst_r = 1'b0; m_rst_prev = 1'b0;
    e_good = 1'b0; e_bad = 1'b0; e_dir = '0;
  endtask

  task automatic model_edge();
    int pc, nx, ny;
    logic acc, hit, food;
    logic [3:0] rose;
    rose = m_dir_r & ~m_dir_prev;
    pc = -1;
    for (int c = 0; c < 4; c++)
      if (m_dir_r == (4'b1000 >> c) && rose == m_dir_r) pc = c;
    acc = (pc >= 0) && (m_state != 2) && (pc != (m_head ^ 1)) && (pc != m_pend);
    e_good = 1'b0;
    e_bad  = 1'b0;
    e_dir  = acc ? (4'b1000 >> pc) : 4'b0000;
    if (m_state == 0) begin
      if (acc) begin m_state = 1; m_since = 0; end
    end else if (m_state == 1) begin
      m_since++;
      if (m_since % TD == 0) begin
        m_head = m_pend;
        nx = int'(m_body[0][7:4]) + dx(m_head);
        ny = int'(m_body[0][3:0]) + dy(m_head);
        hit = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
        for (int i = 1; i <= m_body.size() - 2; i++)
          if (int'(m_body[i][7:4]) == nx && int'(m_body[i][3:0]) == ny) hit = 1'b1;
        if (hit) begin
          e_bad   = 1'b1;
          m_state = 2;
        end else begin
          food = food_valid && (nx == int'(food_x)) && (ny == int'(food_y));
          m_body.push_front({nx[3:0], ny[3:0]});
          if (!food || m_body.size() > ML) void'(m_body.pop_back());
          e_good = food;
        end
      end
    end else if (m_rst_r && !m_rst_prev) begin
      model_reset_game();
    end
    if (acc) m_pend = pc;
    m_dir_prev = m_dir_r;
    m_dir_r    = dir_i;
    m_rst_prev = m_rst_r;
    m_rst_r    = restart_i;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cmp_model();
    logic [19:0] act, exp;
    act = {head_x, head_y, length, dead, good_coll, bad_coll, dir_o};
    exp = {m_body[0], 5'(m_body.size()), (m_state == 2), e_good, e_bad, e_dir};
    check($sformatf("model@%0t", $time), {12'd0, act}, {12'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [3:0] b);
    dir_i = b;
    step();
    dir_i = '0;
    step();
  endtask

  task automatic press_restart();
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    step();
  endtask

  task automatic start_right();
    press(4'b1000);
    press(4'b0001);
  endtask

  task automatic wait_pulse(input logic want_good, input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (want_good ? good_coll : bad_coll) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  typedef struct {
    logic [3:0] dir;
    logic [3:0] hx;
    logic [3:0] hy;
    logic [3:0] dout;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    tbl[0]  = '{4'b0000, 4'd8, 4'd8, 4'b0000};
    tbl[1]  = '{4'b1000, 4'd8, 4'd8, 4'b0000};
    tbl[2]  = '{4'b1000, 4'd8, 4'd8, 4'b1000};
    tbl[3]  = '{4'b1000, 4'd8, 4'd8, 4'b0000};
    tbl[4]  = '{4'b0000, 4'd8, 4'd8, 4'b0000};
    tbl[5]  = '{4'b0000, 4'd8, 4'd8, 4'b0000};
    tbl[6]  = '{4'b0000, 4'd8, 4'd7, 4'b0000};
    tbl[7]  = '{4'b0010, 4'd8, 4'd7, 4'b0000};
    tbl[8]  = '{4'b0000, 4'd8, 4'd7, 4'b0010};
    tbl[9]  = '{4'b0000, 4'd8, 4'd7, 4'b0000};
    tbl[10] = '{4'b0000, 4'd7, 4'd7, 4'b0000};
    tbl[11] = '{4'b1001, 4'd7, 4'd7, 4'b0000};
    tbl[12] = '{4'b0000, 4'd7, 4'd7, 4'b0000};
    tbl[13] = '{4'b0000, 4'd7, 4'd7, 4'b0000};
    tbl[14] = '{4'b0000, 4'd6, 4'd7, 4'b0000};
    tbl[15] = '{4'b0010, 4'd6, 4'd7, 4'b0000};
    tbl[16] = '{4'b0000, 4'd6, 4'd7, 4'b0000};
    tbl[17] = '{4'b0001, 4'd6, 4'd7, 4'b0000};
    tbl[18] = '{4'b0000, 4'd5, 4'd7, 4'b0000};

    // reset state
    model_reset_all();
    repeat (2) @(negedge clk);
    check("reset_state", {head_x, head_y, length, dead, good_coll, bad_coll, dir_o},
          {4'd8, 4'd8, 5'd2, 1'b0, 1'b0, 1'b0, 4'b0000});
    nRst = 1'b1;

    // idle for 100 clocks, then a left press is ignored
    steps(100);
    check("idle_hold", {head_x, head_y, length, dead}, {4'd8, 4'd8, 5'd2, 1'b0});
    press(4'b0010);
    check("idle_left_ignored", {28'd0, dir_o}, 32'd0);

    // table: start, run up, turn left, multi-hot / repeat / reversal rejects
    for (int i = 0; i < 19; i++) begin
      dir_i = tbl[i].dir;
      step();
      check($sformatf("tbl%0d", i), {head_x, head_y, length, dir_o},
            {tbl[i].hx, tbl[i].hy, 5'd2, tbl[i].dout});
    end
    dir_i = '0;

    // asynchronous reset while running, taken just as dir_o is high
    press(4'b1000);
    check("pre_nrst_dir", {28'd0, dir_o}, 32'b1000);
    nRst = 1'b0;
    #1;
    check("nrst_async", {head_x, head_y, length, dead, good_coll, bad_coll, dir_o},
          {4'd8, 4'd8, 5'd2, 1'b0, 1'b0, 1'b0, 4'b0000});
    model_reset_all();
    nRst = 1'b1;

    // food two cells ahead: eaten on the second move, next move keeps length
    food_x = 4'd10; food_y = 4'd8; food_valid = 1'b1;
    start_right();
    wait_pulse(1'b1, 20, "food_wait");
    check("food_eat", {head_x, head_y, length}, {4'd10, 4'd8, 5'd3});
    steps(4);
    check("food_next", {head_x, head_y, length}, {4'd11, 4'd8, 5'd3});

    // wall at the right edge
    food_valid = 1'b0;
    wait_pulse(1'b0, 40, "wall_wait");
    check("wall_hit", {head_x, head_y, length, dead}, {4'd15, 4'd8, 5'd3, 1'b1});
    step();
    check("wall_pulse_once", {bad_coll, dead}, {1'b0, 1'b1});
    press(4'b1000);
    check("dead_press_ignored", {28'd0, dir_o}, 32'd0);
    steps(8);
    check("dead_frozen", {head_x, head_y}, {4'd15, 4'd8});

    // restart from DEAD
    press_restart();
    check("restart", {dead, head_x, head_y, length}, {1'b0, 4'd8, 4'd8, 5'd2});

    // length saturation at MAX_LEN
    food_x = 4'd9; food_y = 4'd8; food_valid = 1'b1;
    start_right();
    for (int k = 0; k < 5; k++) begin
      wait_pulse(1'b1, 20, $sformatf("sat_wait%0d", k));
      check($sformatf("sat_len%0d", k), {head_x, length},
            {4'(9 + k), 5'((3 + k > ML) ? ML : 3 + k)});
      food_x = 4'(10 + k);
    end
    food_valid = 1'b0;
    wait_pulse(1'b0, 40, "sat_wall_wait");
    press_restart();

    // self hit: length 5 then up, left, down
    food_x = 4'd9; food_y = 4'd8; food_valid = 1'b1;
    start_right();
    for (int k = 0; k < 3; k++) begin
      wait_pulse(1'b1, 20, $sformatf("grow_wait%0d", k));
      food_x = 4'(10 + k);
    end
    food_valid = 1'b0;
    check("grow_len", {27'd0, length}, 32'd5);
    press(4'b1000);
    steps(2);
    check("self_up", {head_x, head_y}, {4'd11, 4'd7});
    press(4'b0010);
    steps(2);
    check("self_left", {head_x, head_y}, {4'd10, 4'd7});
    press(4'b0100);
    steps(2);
    check("self_hit", {bad_coll, dead, head_x, head_y, length},
          {1'b1, 1'b1, 4'd10, 4'd7, 5'd5});
    press_restart();

    // randomized play against the model
    for (int c = 0; c < 2500; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) dir_i = 4'b0001 << $urandom_range(0, 3);
      else if (r < 8) dir_i = 4'($urandom);
      else if (r >= 14) dir_i = '0;
      restart_i = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) begin
        food_valid = ($urandom_range(0, 4) != 0);
        food_x = m_body[0][7:4] + 4'($urandom_range(0, 2)) - 4'd1;
        food_y = m_body[0][3:0] + 4'($urandom_range(0, 2)) - 4'd1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
